rx_sample_capture: RTL and testbench
====================================

Name: rx_sample_capture

Overview:
Parametrised multi-channel, trigger-based capture buffer for the OFDM RX sample path in the sample-clock domain. It keeps a rolling pre-trigger history of NUM_CH channels of ADC/sync samples. On a trigger (typically packet detect) it completes a capture of programmable length. It then drains the samples, oldest first, over a valid/ready stream toward a readout FIFO. It generalises the single-channel fixed sample hand-off to N channels, configurable depth and pre-trigger, and adds backpressure.

Parameters:
NUM_CH, 2, number of sample channels (I/Q pairs count as 2); range 1..8
DATA_W, 16, bits per channel sample
ADDR_W, 10, buffer depth is 2^ADDR_W entries of NUM_CH*DATA_W bits

Ports:
clk  in  1  sample clock
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  input sample strobe
in_data  in  NUM_CH*DATA_W  channel samples; ch0 in LSBs
trig  in  1  capture trigger, level-sampled each cycle
arm  in  1  start-capture request; 1-cycle pulse
cfg_len  in  ADDR_W  total samples per capture
cfg_pretrig  in  ADDR_W  samples kept from before the trigger
out_valid  out  1  output sample valid
out_ready  in  1  downstream accept
out_data  out  NUM_CH*DATA_W  output sample
out_last  out  1  marks final sample of a capture
state  out  3  current FSM state code
done  out  1  1-cycle pulse after the last handshake
cfg_err  out  1  1-cycle pulse when arm is rejected
trig_ts  out  32  sample timestamp of trigger (optional feature)

Behaviour:
- Reset values: out_valid, out_last, done and cfg_err are 0; state is IDLE; trig_ts is 0; all pointers and counters are 0. Buffer contents are undefined.
- Reset mid-operation aborts any capture or drain immediately. No out_last or done is produced.
- FSM codes: IDLE=0, FILL=1, ARMED=2, CAPTURE=3, DRAIN=4.
- IDLE: arm with 1<=cfg_len<=2^ADDR_W-1 and cfg_pretrig<cfg_len latches both configs and clears the write pointer and count.
  - Goes to FILL, or straight to ARMED if cfg_pretrig=0.
  - An invalid config gives a cfg_err pulse next cycle and stays in IDLE.
  - arm outside IDLE is ignored with no error.
- FILL: each in_valid writes in_data at wptr; wptr increments mod 2^ADDR_W; count increments.
  - On the write making count==pretrig, go to ARMED.
  - trig is ignored in FILL, so the history is guaranteed complete before a trigger is accepted.
- ARMED: writes continue and wrap circularly.
  - On trig=1, go to CAPTURE and record trig_ptr=wptr.
  - If in_valid is high on the trigger cycle, that sample is the first post-trigger sample.
- CAPTURE: writes continue until post-trigger samples total cfg_len-cfg_pretrig, then go to DRAIN. trig is ignored.
- DRAIN: read start = (trig_ptr - cfg_pretrig) mod 2^ADDR_W; cfg_len entries are read in order, wrapping.
  - in_valid is ignored; samples are dropped.
  - The memory is synchronous-read with 1-cycle latency. The output is registered with a 2-entry skid.
  - out_valid rises no later than 2 cycles after entering DRAIN.
  - Full throughput is 1 sample/cycle while out_ready=1.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - out_last is high only with the cfg_len-th sample.
  - On the out_last handshake, go to IDLE; done pulses the following cycle. out_valid is 0 in every state except DRAIN.
- Boundaries:
  - cfg_len=1, pretrig=0: one sample is captured on the first valid at or after trigger.
  - Pointer wrap is exact for any trigger position.
  - arm on the same cycle as the done pulse is accepted.

Optional Feature:
Macro RX_CAPTURE_TS_EN.
- Defined: a 32-bit free-running counter increments on every in_valid, wrapping at 2^32, and resets to 0.
  - trig_ts latches the counter value on the trigger-accept cycle, i.e. the index of the first post-trigger sample.
  - trig_ts holds until the next trigger accept.
- Undefined: the port is present and tied to 0, and no counter is built.

Test Plan:
- NUM_CH=2, ADDR_W=4; arm, len=8, pretrig=3; in_valid continuous with ramp data 0,1,2…; trig at sample value 10 -> drains 7,8,9,10,11,12,13,14 with out_last on 14, then done pulse.
- Same config, but trig asserted while in FILL (after 1 sample) -> ignored. A later trig at sample 20 gives 17..24.
- Pretrig window spanning pointer wrap (trigger at sample 33, len=15, pretrig=10) -> output 23..37 in order, no gaps.
- out_ready toggled 1,0,0,1 pseudo-randomly during drain -> no duplicated or dropped samples; out_data stable while stalled.
- Invalid arm (len=0, or pretrig=len=5) -> cfg_err pulse, state stays 0. Arm during CAPTURE -> ignored. rst pulsed mid-DRAIN -> state 0, out_valid 0 next cycle.
- With RX_CAPTURE_TS_EN: in_valid every 2nd cycle, trig at the 50th valid -> trig_ts=49. Without the macro -> trig_ts=0.

Source files
------------

// File: rtl/rx_capture_if.sv
// Sample-in / capture-out bundle for rx_sample_capture. The slave modport is the
// capture block's view; master is the source/sink side.
interface rx_capture_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    localparam int W = NUM_CH * DATA_W;

    logic              in_valid;
    logic [W-1:0]      in_data;
    logic              trig;
    logic              arm;
    logic [ADDR_W-1:0] cfg_len;
    logic [ADDR_W-1:0] cfg_pretrig;

    // out_valid/out_ready: a transfer happens on every clock edge where both are
    // high; once out_valid rises, out_data/out_last hold until that transfer.
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic              out_last;

    logic [2:0]        state;
    logic              done;
    logic              cfg_err;
    logic [31:0]       trig_ts;

    modport master (
        output in_valid, in_data, trig, arm, cfg_len, cfg_pretrig, out_ready,
        input  out_valid, out_data, out_last, state, done, cfg_err, trig_ts
    );

    modport slave (
        input  in_valid, in_data, trig, arm, cfg_len, cfg_pretrig, out_ready,
        output out_valid, out_data, out_last, state, done, cfg_err, trig_ts
    );
endinterface

// File: rtl/rx_sample_capture.sv
// Trigger-based multi-channel capture buffer: rolling pre-trigger history, post-trigger
// fill, then oldest-first drain through a 2-entry skid. Define RX_CAPTURE_TS_EN for trig_ts.
module rx_sample_capture #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    rx_capture_if.slave bus
);
    localparam int W     = NUM_CH * DATA_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_ARMED   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_len, r_pre, r_wptr, r_rptr, r_cnt, r_rd_rem;
    logic [W-1:0]      r_mem [DEPTH];
    logic [W-1:0]      r_rd_data;
    logic              r_rd_pend, r_rd_last;
    logic [W-1:0]      r_q_data [2];
    logic [1:0]        r_q_last;
    logic [1:0]        r_fcnt;
    logic              r_done, r_cfg_err;

    logic              w_cfg_ok, w_arm_ok, w_trig_acc, w_wr_en;
    logic              w_out_valid, w_pop, w_push, w_issue;
    logic [ADDR_W-1:0] w_post_tgt;
    logic [1:0]        w_occ;

    assign w_cfg_ok    = (bus.cfg_len != '0) && (bus.cfg_pretrig < bus.cfg_len);
    assign w_post_tgt  = r_len - r_pre;
    assign w_wr_en     = bus.in_valid && (r_state inside {S_FILL, S_ARMED, S_CAPTURE});
    assign w_out_valid = (r_fcnt != 2'd0);
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_push      = r_rd_pend;
    // Reads in flight plus skid entries never exceed 2, so the skid cannot overflow.
    assign w_occ       = r_fcnt + {1'b0, r_rd_pend};
    assign w_issue     = (r_state == S_DRAIN) && (r_rd_rem != '0) && ((w_occ != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_arm_ok   = 1'b0;
        w_trig_acc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.arm && w_cfg_ok) begin
                    w_arm_ok = 1'b1;
                    w_next   = (bus.cfg_pretrig == '0) ? S_ARMED : S_FILL;
                end
            end
            S_FILL: begin
                if (bus.in_valid && (r_cnt + ONE == r_pre)) w_next = S_ARMED;
            end
            S_ARMED: begin
                if (bus.trig) begin
                    w_trig_acc = 1'b1;
                    // A sample on the trigger cycle may already complete a 1-sample post window.
                    w_next = (bus.in_valid && (w_post_tgt == ONE)) ? S_DRAIN : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (bus.in_valid && (r_cnt + ONE == w_post_tgt)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pop && r_q_last[0]) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_pre       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_rd_rem    <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_last   <= 1'b0;
            r_q_data[0] <= '0;
            r_q_data[1] <= '0;
            r_q_last    <= '0;
            r_fcnt      <= '0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            if (w_arm_ok) begin
                r_len    <= bus.cfg_len;
                r_pre    <= bus.cfg_pretrig;
                r_rd_rem <= bus.cfg_len;
            end else if (w_issue) begin
                r_rd_rem <= r_rd_rem - ONE;
            end

            if (w_arm_ok)     r_wptr <= '0;
            else if (w_wr_en) r_wptr <= r_wptr + ONE;

            // Counts pre-trigger history in FILL, then post-trigger samples after the trigger.
            if (w_arm_ok)        r_cnt <= '0;
            else if (w_trig_acc) r_cnt <= bus.in_valid ? ONE : '0;
            else if (w_wr_en)    r_cnt <= r_cnt + ONE;

            if (w_trig_acc)   r_rptr <= r_wptr - r_pre;
            else if (w_issue) r_rptr <= r_rptr + ONE;

            r_rd_pend <= w_issue;
            r_rd_last <= w_issue && (r_rd_rem == ONE);

            case ({w_push, w_pop})
                2'b10: begin
                    if (r_fcnt == 2'd0) begin
                        r_q_data[0] <= r_rd_data;
                        r_q_last[0] <= r_rd_last;
                    end else begin
                        r_q_data[1] <= r_rd_data;
                        r_q_last[1] <= r_rd_last;
                    end
                    r_fcnt <= r_fcnt + 2'd1;
                end
                2'b01: begin
                    r_q_data[0] <= r_q_data[1];
                    r_q_last[0] <= r_q_last[1];
                    r_fcnt      <= r_fcnt - 2'd1;
                end
                2'b11: begin
                    if (r_fcnt == 2'd1) begin
                        r_q_data[0] <= r_rd_data;
                        r_q_last[0] <= r_rd_last;
                    end else begin
                        r_q_data[0] <= r_q_data[1];
                        r_q_last[0] <= r_q_last[1];
                        r_q_data[1] <= r_rd_data;
                        r_q_last[1] <= r_rd_last;
                    end
                end
                default: ;
            endcase

            r_done    <= w_pop && r_q_last[0];
            r_cfg_err <= (r_state == S_IDLE) && bus.arm && !w_cfg_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wptr] <= bus.in_data;
        if (w_issue) r_rd_data <= r_mem[r_rptr];
    end

`ifdef RX_CAPTURE_TS_EN
    logic [31:0] r_ts_cnt, r_trig_ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts_cnt  <= '0;
            r_trig_ts <= '0;
        end else begin
            if (bus.in_valid) r_ts_cnt  <= r_ts_cnt + 32'd1;
            if (w_trig_acc)   r_trig_ts <= r_ts_cnt;
        end
    end

    assign bus.trig_ts = r_trig_ts;
`else
    assign bus.trig_ts = 32'd0;
`endif

    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_q_data[0];
    assign bus.out_last  = r_q_last[0] && w_out_valid;
    assign bus.state     = r_state;
    assign bus.done      = r_done;
    assign bus.cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_rx_sample_capture.sv
// Bench for rx_sample_capture: table of directed captures, randomized captures against a
// sample-stream reference model, and hand-written arm/reset corner sequences.
module tb_rx_sample_capture;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int W      = NUM_CH * DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rx_capture_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rx_sample_capture #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit rst_first;
        int len;
        int pre;
        int toff;
        int eoff;
        int vpct;
        int rpct;
        bit poke;
        int abort_at;
        int exp_first;
        int exp_n;
    } row_t;

    int n_vec = 0;
    int n_err = 0;
    int ramp = 0;
    int vcount = 0;
    int unsigned ts_exp = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] mk(input int v);
        logic [15:0] a;
        a = v[15:0];
        return {~a, a};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.trig = 1'b0; bus.arm = 1'b0;
        bus.cfg_len = '0; bus.cfg_pretrig = '0; bus.out_ready = 1'b0;
        ramp = 0; vcount = 0; exp_q.delete();
        repeat (2) @(negedge clk);
        check("rst_state", 64'(bus.state), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
        check("rst_trig_ts", 64'(bus.trig_ts), 64'd0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs one arm..done capture; called and returning at a falling edge.
    task automatic capture(input row_t r, output int first, output int n_out, output bit aborted);
        int hist[$];
        int phase, post, dcyc, t_at, e_at;
        bit hold, ended, fin, stalled, poked, poke_chk, rdy, v, alt;
        logic [W-1:0] prev_data, e;
        logic prev_last;
        first = -1; n_out = 0; aborted = 1'b0;
        phase = 0; post = 0; dcyc = -1;
        hold = 0; ended = 0; fin = 0; stalled = 0; poked = 0; poke_chk = 0; alt = 0;
        prev_data = '0; prev_last = 1'b0;
        t_at = ramp + r.toff;
        e_at = (r.eoff < 0) ? -1 : ramp + r.eoff;
        bus.arm = 1'b1; bus.cfg_len = ADDR_W'(r.len); bus.cfg_pretrig = ADDR_W'(r.pre);
        bus.in_valid = 1'b0; bus.trig = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.arm = 1'b0;
        check("arm_state", 64'(bus.state), (r.pre == 0) ? 64'd2 : 64'd1);
        check("arm_no_err", 64'(bus.cfg_err), 64'd0);
        check("done_one_cycle", 64'(bus.done), 64'd0);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (r.abort_at >= 0 && n_out == r.abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_state", 64'(bus.state), 64'd0);
                check("abort_out_valid", 64'(bus.out_valid), 64'd0);
                @(negedge clk);
                check("abort_done", 64'(bus.done), 64'd0);
                check("abort_out_last", 64'(bus.out_last), 64'd0);
                rst = 1'b0;
                ramp = 0; vcount = 0; exp_q.delete();
                aborted = 1'b1; fin = 1;
            end else if (ended) begin
                check("done_pulse", 64'(bus.done), 64'd1);
                check("end_state", 64'(bus.state), 64'd0);
                check("end_out_valid", 64'(bus.out_valid), 64'd0);
                fin = 1;
            end else begin
                if (poke_chk) begin
                    check("arm_in_capture_no_err", 64'(bus.cfg_err), 64'd0);
                    poke_chk = 0;
                end
                if (phase == 2) dcyc++;
                if (phase < 2) check("no_valid_before_drain", 64'(bus.out_valid), 64'd0);
                if (dcyc == 0) check("drain_state", 64'(bus.state), 64'd4);
                if (dcyc == 2 && n_out == 0) check("drain_latency", 64'(bus.out_valid), 64'd1);
                if (r.rpct == 100 && n_out > 0) check("throughput", 64'(bus.out_valid), 64'd1);
                if (stalled) begin
                    check("stall_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_data", 64'(bus.out_data), 64'(prev_data));
                    check("stall_last", 64'(bus.out_last), 64'(prev_last));
                end
                rdy = ($urandom_range(99) < r.rpct);
                bus.out_ready = rdy;
                stalled = bus.out_valid && !rdy;
                prev_data = bus.out_data;
                prev_last = bus.out_last;
                if (bus.out_valid && rdy) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL extra_sample: got 0x%0h, expected no sample at %0t", bus.out_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 64'(bus.out_data), 64'(e));
                        check("out_last", 64'(bus.out_last), 64'(exp_q.size() == 0 && phase == 2));
                        if (n_out == 0) first = int'(bus.out_data[15:0]);
                        n_out++;
                        if (exp_q.size() == 0 && phase == 2) ended = 1;
                    end
                end
            end
            if (!fin) begin
                if (r.vpct < 0) begin
                    alt = !alt;
                    v = alt;
                end else begin
                    v = ($urandom_range(99) < r.vpct);
                end
                bus.in_valid = v;
                bus.in_data = v ? mk(ramp) : W'($urandom);
                if (ramp == t_at) hold = 1;
                bus.trig = hold || (ramp == e_at) || (phase != 0 && $urandom_range(3) == 0);
                bus.arm = 1'b0;
                if (r.poke && phase == 1 && !poked) begin
                    bus.arm = 1'b1; bus.cfg_len = '0; bus.cfg_pretrig = '0;
                    poked = 1; poke_chk = 1;
                end
                // Trigger is honoured once the pre-trigger history is complete.
                if (phase == 0 && bus.trig && hist.size() >= r.pre) begin
                    for (int i = hist.size() - r.pre; i < hist.size(); i++) exp_q.push_back(mk(hist[i]));
                    ts_exp = vcount;
                    phase = 1;
                    hold = 0;
                end
                if (v) begin
                    if (phase == 0) begin
                        hist.push_back(ramp);
                    end else if (phase == 1) begin
                        exp_q.push_back(mk(ramp));
                        post++;
                        if (post == r.len - r.pre) phase = 2;
                    end
                    ramp++;
                    vcount++;
                end
                @(negedge clk);
            end
        end
        if (!fin) begin
            n_vec++; n_err++;
            $display("FAIL capture_timeout: got %0d samples, expected %0d at %0t", n_out, r.len, $time);
        end
        bus.in_valid = 1'b0; bus.trig = 1'b0; bus.arm = 1'b0;
    endtask

    task automatic run_row(input row_t r);
        int first, n_out;
        bit aborted;
        if (r.rst_first) do_reset();
        capture(r, first, n_out, aborted);
        if (!aborted) begin
            if (r.exp_first >= 0) check("first_sample", 64'(first), 64'(r.exp_first));
            if (r.exp_n >= 0) check("sample_count", 64'(n_out), 64'(r.exp_n));
            check("leftover_expected", 64'(exp_q.size()), 64'd0);
`ifdef RX_CAPTURE_TS_EN
            check("trig_ts", 64'(bus.trig_ts), 64'(ts_exp));
`else
            check("trig_ts_tied", 64'(bus.trig_ts), 64'd0);
`endif
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        row_t rows[10];
        row_t rr;
        int bad_len[3];
        int bad_pre[3];

        //          rst len pre toff eoff vpct rpct poke abort first n
        rows[0] = '{1, 8,  3,  10,  -1, 100, 100, 0, -1,  7,  8};
        rows[1] = '{1, 8,  3,  20,   1, 100, 100, 0, -1, 17,  8};
        rows[2] = '{1, 15, 10, 33,  -1, 100, 100, 0, -1, 23, 15};
        rows[3] = '{0, 8,  3,  6,   -1, 100, 50,  0, -1, -1,  8};
        rows[4] = '{0, 1,  0,  5,   -1, 50,  100, 0, -1, -1,  1};
        rows[5] = '{0, 15, 14, 20,  -1, 100, 70,  0, -1, -1, 15};
        rows[6] = '{0, 6,  2,  3,   -1, 80,  60,  1, -1, -1,  6};
        rows[7] = '{1, 8,  3,  4,   -1, 100, 100, 0,  3, -1, -1};
        rows[8] = '{1, 4,  2,  49,  -1, -1,  100, 0, -1, 47,  4};
        rows[9] = '{0, 5,  0,  0,   -1, 100, 100, 0, -1, -1,  5};

        do_reset();
        for (int k = 0; k < 10; k++) run_row(rows[k]);

        for (int k = 0; k < 8; k++) begin
            rr.rst_first = 0;
            rr.len       = $urandom_range(15, 1);
            rr.pre       = $urandom_range(rr.len - 1, 0);
            rr.toff      = $urandom_range(30, 0);
            rr.eoff      = -1;
            rr.vpct      = $urandom_range(100, 30);
            rr.rpct      = $urandom_range(100, 20);
            rr.poke      = $urandom_range(1, 0);
            rr.abort_at  = -1;
            rr.exp_first = -1;
            rr.exp_n     = rr.len;
            run_row(rr);
        end

        bad_len = '{0, 5, 3};
        bad_pre = '{0, 5, 7};
        for (int k = 0; k < 3; k++) begin
            bus.arm = 1'b1;
            bus.cfg_len = ADDR_W'(bad_len[k]);
            bus.cfg_pretrig = ADDR_W'(bad_pre[k]);
            @(negedge clk);
            bus.arm = 1'b0;
            check("bad_arm_err", 64'(bus.cfg_err), 64'd1);
            check("bad_arm_state", 64'(bus.state), 64'd0);
            @(negedge clk);
            check("bad_arm_err_pulse", 64'(bus.cfg_err), 64'd0);
            check("bad_arm_state_hold", 64'(bus.state), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
